// File: rtl/des_pkg.sv
// Shared types and constants for the time-shared DES core arbiter.
package des_pkg;

  localparam int unsigned BLK_W = 64;
  localparam int unsigned KEY_W = 64;

  localparam logic DES_ENC = 1'b0;
  localparam logic DES_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Operand bundle handed to the core for one operation.
  typedef struct packed {
    logic             mode;
    logic [BLK_W-1:0] data;
    logic [KEY_W-1:0] key;
  } des_op_t;

endpackage

// File: rtl/des_core_arbiter_rr_arb2.sv
// Two-way round-robin grant: with both requesting, the one not granted last wins.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic any_c,
  output logic grant_c
);

  assign any_c   = valid0 | valid1;
  assign grant_c = (valid0 & valid1) ? ~last_grant : valid1;

endmodule

// File: rtl/des_core_arbiter.sv
// Time-shares one DES core between two requesters with round-robin arbitration,
// a bounded wait on the core and a valid/ready result return per channel.
module des_core_arbiter
  import des_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = 7
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  input  logic             req0_mode,
  input  logic [BLK_W-1:0] req0_data,
  input  logic [KEY_W-1:0] req0_key,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [BLK_W-1:0] rsp0_data,
  input  logic             rsp0_ready,

  input  logic             req1_valid,
  input  logic             req1_mode,
  input  logic [BLK_W-1:0] req1_data,
  input  logic [KEY_W-1:0] req1_key,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [BLK_W-1:0] rsp1_data,
  input  logic             rsp1_ready,

  output logic             des_enable,
  output logic             des_mode,
  output logic [BLK_W-1:0] des_data,
  output logic [KEY_W-1:0] des_key,
  input  logic             des_ready,
  input  logic [BLK_W-1:0] des_result,

  output logic             busy,
  output logic             timeout_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  arb_state_e      state;
  logic            last_grant;
  logic            owner;
  logic [TO_W-1:0] to_cnt;

  logic            any_c;
  logic            grant_c;
  des_op_t         sel_op_c;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .any_c      (any_c),
    .grant_c    (grant_c)
  );

  assign sel_op_c = grant_c ? {req1_mode, req1_data, req1_key}
                            : {req0_mode, req0_data, req0_key};

  // Accept strobes are only ever raised while idle and out of reset.
  assign req0_ready = rst & (state == IDLE) & any_c & ~grant_c;
  assign req1_ready = rst & (state == IDLE) & any_c &  grant_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      to_cnt      <= '0;
      des_enable  <= 1'b0;
      des_mode    <= DES_ENC;
      des_data    <= '0;
      des_key     <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_data   <= '0;
      rsp1_data   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      des_enable  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_c) begin
            {des_mode, des_data, des_key} <= sel_op_c;
            owner      <= grant_c;
            last_grant <= grant_c;
            to_cnt     <= '0;
            des_enable <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Counter tracks cycles elapsed since the start pulse.
          to_cnt <= TO_W'(1);
          state  <= WAIT;
        end
        WAIT: begin
          if (des_ready) begin
            if (owner) begin
              rsp1_data  <= des_result;
              rsp1_valid <= 1'b1;
            end else begin
              rsp0_data  <= des_result;
              rsp0_valid <= 1'b1;
            end
            state <= RESP;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
